// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and width helper
// for the spi_slave_cfg slice.
package spi_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t LOAD   = 2'd1;
  localparam state_t ACTIVE = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1)
      r++;
    return r;
  endfunction

endpackage

// File: rtl/spi_cfg_if.sv
// spi_cfg_if: parallel side of the SPI slave.
// TX valid/ready, RX pulse, status pulses, busy.
interface spi_cfg_if #(
  parameter int NB_BITS = 32
);

  logic [NB_BITS-1:0] i_tx_data;
  logic               i_tx_valid;
  logic               o_tx_ready;
  logic [NB_BITS-1:0] o_rx_data;
  logic               o_rx_valid;
  logic               o_underrun;
  logic               o_abort;
  logic               o_busy;

  modport slave (
    input  i_tx_data,
    input  i_tx_valid,
    output o_tx_ready,
    output o_rx_data,
    output o_rx_valid,
    output o_underrun,
    output o_abort,
    output o_busy
  );

  modport master (
    output i_tx_data,
    output i_tx_valid,
    input  o_tx_ready,
    input  o_rx_data,
    input  o_rx_valid,
    input  o_underrun,
    input  o_abort,
    input  o_busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: NB_SYNC-flop synchroniser plus a level
// register; i_d -> o_lvl/o_rise/o_fall, latency NB_SYNC+1.
module spi_sync_edge #(
  parameter int   NB_SYNC = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic [NB_SYNC-1:0] r_sync;
  logic               r_lvl;
  logic               r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {NB_SYNC{RST_VAL}};
      r_lvl  <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[NB_SYNC-2:0], i_d};
      r_lvl  <= r_sync[NB_SYNC-1];
      r_prev <= r_lvl;
    end
  end

  assign o_lvl  = r_lvl;
  assign o_rise = r_lvl & ~r_prev;
  assign o_fall = ~r_lvl & r_prev;

endmodule

// File: rtl/spi_slave_cfg.sv
// spi_slave_cfg: oversampled SPI slave, all CPOL/CPHA modes.
// Pins: i_sclk/i_mosi/i_cs_n in, o_miso/o_miso_oe out;
// bus: TX valid/ready, RX pulse, underrun/abort, busy.
module spi_slave_cfg
  import spi_pkg::*;
#(
  parameter int NB_BITS   = 32,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1,
  parameter int NB_SYNC   = 2
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_sclk,
  input  logic     i_mosi,
  input  logic     i_cs_n,
  output logic     o_miso,
  output logic     o_miso_oe,
  spi_cfg_if.slave bus
);

  localparam int CW = clog2(NB_BITS);
  localparam logic [CW-1:0] LAST = CW'(NB_BITS - 1);

  state_t r_state;
  state_t w_next;

  logic w_unused_sck;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_cs_lvl;
  logic w_unused_csr;
  logic w_cs_fall;
  logic w_mosi;
  logic w_unused_mr;
  logic w_unused_mf;

  logic [NB_BITS-1:0] r_hold;
  logic               r_full;
  logic [NB_BITS-1:0] r_tx_sr;
  logic [NB_BITS-1:0] r_rx_sr;
  logic [NB_BITS-1:0] r_rx_data;
  logic [CW-1:0]      r_bit_cnt;
  logic               r_first;
  logic               r_empty_ld;
  logic               r_rx_valid;
  logic               r_underrun;
  logic               r_abort;

  logic               w_lead;
  logic               w_trail;
  logic               w_act;
  logic               w_sample;
  logic               w_shift;
  logic               w_done;
  logic               w_wr;
  logic               w_load;
  logic               w_abort;
  logic               w_busy;
  logic [NB_BITS-1:0] w_rx_next;

  spi_sync_edge #(.NB_SYNC(NB_SYNC), .RST_VAL(CPOL)) u_sck (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (i_sclk),
    .o_lvl  (w_unused_sck),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  spi_sync_edge #(.NB_SYNC(NB_SYNC), .RST_VAL(1'b1)) u_cs (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (i_cs_n),
    .o_lvl  (w_cs_lvl),
    .o_rise (w_unused_csr),
    .o_fall (w_cs_fall)
  );

  spi_sync_edge #(.NB_SYNC(NB_SYNC), .RST_VAL(1'b0)) u_mosi (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (i_mosi),
    .o_lvl  (w_mosi),
    .o_rise (w_unused_mr),
    .o_fall (w_unused_mf)
  );

  assign w_lead   = CPOL ? w_sck_fall : w_sck_rise;
  assign w_trail  = CPOL ? w_sck_rise : w_sck_fall;
  assign w_act    = (r_state == ACTIVE) && !w_cs_lvl;
  assign w_sample = w_act && (CPHA ? w_trail : w_lead);
  assign w_shift  = w_act && (CPHA ? w_lead : w_trail);
  assign w_done   = w_sample && (r_bit_cnt == LAST);
  assign w_wr     = bus.i_tx_valid && !r_full;

  assign w_rx_next = MSB_FIRST ?
    {r_rx_sr[NB_BITS-2:0], w_mosi} :
    {w_mosi, r_rx_sr[NB_BITS-1:1]};

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_cs_fall) w_next = LOAD;
      LOAD:    w_next = w_cs_lvl ? IDLE : ACTIVE;
      ACTIVE:  if (w_cs_lvl) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_load  = 1'b0;
    w_abort = 1'b0;
    w_busy  = 1'b0;
    unique case (r_state)
      IDLE: begin
      end
      LOAD: begin
        w_load = 1'b1;
        w_busy = 1'b1;
      end
      ACTIVE: begin
        w_load  = w_done;
        w_abort = w_cs_lvl && (r_bit_cnt != '0);
        w_busy  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // A fresh word's first bit is already on MISO after a
  // load, so the next shift edge is swallowed unless a
  // sample edge came first (frame start with CPHA=0).
  // Underrun is flagged at the first sample of a word, so
  // the reload after a frame's last word never reports.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold     <= '0;
      r_full     <= 1'b0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_rx_data  <= '0;
      r_bit_cnt  <= '0;
      r_first    <= 1'b0;
      r_empty_ld <= 1'b0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= w_abort;

      if (w_load && r_full) begin
        r_full <= 1'b0;
      end else if (w_wr) begin
        r_full <= 1'b1;
        r_hold <= bus.i_tx_data;
      end

      if (w_load) begin
        r_tx_sr    <= r_full ? r_hold : '0;
        r_empty_ld <= !r_full;
        r_first    <= 1'b1;
      end else if (w_shift) begin
        r_first <= 1'b0;
        if (!r_first)
          r_tx_sr <= MSB_FIRST ? r_tx_sr << 1 : r_tx_sr >> 1;
      end else if (w_sample) begin
        r_first <= 1'b0;
      end

      if (w_sample) begin
        r_rx_sr <= w_rx_next;
        if (r_bit_cnt == '0 && r_empty_ld)
          r_underrun <= 1'b1;
        if (w_done) begin
          r_bit_cnt  <= '0;
          r_rx_data  <= w_rx_next;
          r_rx_valid <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end

      if (r_state != ACTIVE)
        r_bit_cnt <= '0;
    end
  end

  assign o_miso_oe = ~w_cs_lvl;
  assign o_miso    = o_miso_oe &
    (MSB_FIRST ? r_tx_sr[NB_BITS-1] : r_tx_sr[0]);

  assign bus.o_tx_ready = ~r_full;
  assign bus.o_rx_data  = r_rx_data;
  assign bus.o_rx_valid = r_rx_valid;
  assign bus.o_underrun = r_underrun;
  assign bus.o_abort    = r_abort;
  assign bus.o_busy     = w_busy;

endmodule
